// File: rtl/q_update.sv
// Temporal-difference Q update engine: reads Q(s',.) then Q(s,.), computes the TD target and writes Q(s,a).
// Optional build macro Q_UPDATE_SATURATE_EN clamps the new Q value instead of wrapping it.
module q_update #(
    parameter int                     DATA_LENGTH   = 32,
    parameter int                     ACCESS_LENGTH = 8,
    parameter int                     FRAC_BITS     = 16,
    parameter logic [DATA_LENGTH-1:0] GAMMA         = 32'h0000E666,
    parameter int                     ALPHA_SHIFT   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic                       ready,
    input  logic [ACCESS_LENGTH-1:0]   state,
    input  logic [1:0]                 action,
    input  logic [ACCESS_LENGTH-1:0]   next_state,
    input  logic [DATA_LENGTH-1:0]     reward,
    input  logic                       terminal,
    output logic [ACCESS_LENGTH-1:0]   r_address,
    input  logic [4*DATA_LENGTH-1:0]   r_data,
    output logic                       w_en,
    output logic [ACCESS_LENGTH-1:0]   w_address,
    output logic [1:0]                 w_action,
    output logic [DATA_LENGTH-1:0]     w_data,
    output logic                       done,
    output logic [1:0]                 max_action
);

    localparam int EW = DATA_LENGTH + 2;
    localparam int PW = 2 * DATA_LENGTH + 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_NEXT,
        RD_CUR,
        CALC,
        WRITE
    } fsm_t;

    fsm_t                      fsm_q, fsm_d;
    logic [ACCESS_LENGTH-1:0]  s_q, s_d;
    logic [1:0]                a_q, a_d;
    logic signed [DATA_LENGTH-1:0] r_q, r_d;
    logic                      term_q, term_d;
    logic signed [DATA_LENGTH-1:0] maxq_q, maxq_d;
    logic signed [DATA_LENGTH-1:0] q_sa_q, q_sa_d;
    logic [1:0]                max_action_q, max_action_d;
    logic [ACCESS_LENGTH-1:0]  r_address_q, r_address_d;
    logic                      ready_q, ready_d;
    logic                      w_en_q, w_en_d;
    logic                      done_q, done_d;
    logic [ACCESS_LENGTH-1:0]  w_address_q, w_address_d;
    logic [1:0]                w_action_q, w_action_d;
    logic [DATA_LENGTH-1:0]    w_data_q, w_data_d;

    logic signed [DATA_LENGTH-1:0] row_word [4];
    logic signed [DATA_LENGTH-1:0] best_val;
    logic [1:0]                    best_idx;

    logic signed [PW-1:0]          gamma_ext;
    logic signed [PW-1:0]          maxq_ext;
    logic signed [PW-1:0]          prod;
    logic signed [EW-1:0]          g_ext;
    logic signed [EW-1:0]          r_ext;
    logic signed [EW-1:0]          q_ext;
    logic signed [EW-1:0]          target;
    logic signed [EW-1:0]          delta;
    logic signed [EW-1:0]          new_ext;
    logic [DATA_LENGTH-1:0]        new_val;

`ifdef Q_UPDATE_SATURATE_EN
    localparam logic signed [EW-1:0] SAT_MAX = {3'b000, {(DATA_LENGTH-1){1'b1}}};
    localparam logic signed [EW-1:0] SAT_MIN = {3'b111, {(DATA_LENGTH-1){1'b0}}};
`endif

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            row_word[k] = r_data[k*DATA_LENGTH +: DATA_LENGTH];
        end
    end

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        best_val = row_word[0];
        best_idx = 2'd0;
        for (int k = 1; k < 4; k++) begin
            if (row_word[k] > best_val) begin
                best_val = row_word[k];
                best_idx = 2'(k);
            end
        end
    end

    always_comb begin
        gamma_ext = {{(PW-DATA_LENGTH){1'b0}}, GAMMA};
        maxq_ext  = {{(PW-DATA_LENGTH){maxq_q[DATA_LENGTH-1]}}, maxq_q};
        prod      = gamma_ext * maxq_ext;
        g_ext     = EW'(prod >>> FRAC_BITS);
        r_ext     = {{2{r_q[DATA_LENGTH-1]}}, r_q};
        q_ext     = {{2{q_sa_q[DATA_LENGTH-1]}}, q_sa_q};
        target    = term_q ? r_ext : r_ext + g_ext;
        delta     = target - q_ext;
        new_ext   = q_ext + (delta >>> ALPHA_SHIFT);
`ifdef Q_UPDATE_SATURATE_EN
        if (new_ext > SAT_MAX) begin
            new_val = {1'b0, {(DATA_LENGTH-1){1'b1}}};
        end else if (new_ext < SAT_MIN) begin
            new_val = {1'b1, {(DATA_LENGTH-1){1'b0}}};
        end else begin
            new_val = DATA_LENGTH'(new_ext);
        end
`else
        new_val = DATA_LENGTH'(new_ext);
`endif
    end

    // r_address is loaded on the edge entering each read state so r_data is valid during that state.
    always_comb begin
        fsm_d        = fsm_q;
        s_d          = s_q;
        a_d          = a_q;
        r_d          = r_q;
        term_d       = term_q;
        maxq_d       = maxq_q;
        q_sa_d       = q_sa_q;
        max_action_d = max_action_q;
        r_address_d  = r_address_q;
        w_en_d       = 1'b0;
        done_d       = 1'b0;
        w_address_d  = w_address_q;
        w_action_d   = w_action_q;
        w_data_d     = w_data_q;

        case (fsm_q)
            IDLE: begin
                if (start) begin
                    s_d         = state;
                    a_d         = action;
                    r_d         = reward;
                    term_d      = terminal;
                    r_address_d = next_state;
                    fsm_d       = RD_NEXT;
                end
            end
            RD_NEXT: begin
                maxq_d       = best_val;
                max_action_d = best_idx;
                r_address_d  = s_q;
                fsm_d        = RD_CUR;
            end
            RD_CUR: begin
                q_sa_d = row_word[a_q];
                fsm_d  = CALC;
            end
            CALC: begin
                w_en_d      = 1'b1;
                done_d      = 1'b1;
                w_address_d = s_q;
                w_action_d  = a_q;
                w_data_d    = new_val;
                fsm_d       = WRITE;
            end
            WRITE: begin
                fsm_d = IDLE;
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase

        ready_d = (fsm_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fsm_q        <= IDLE;
            s_q          <= '0;
            a_q          <= '0;
            r_q          <= '0;
            term_q       <= 1'b0;
            maxq_q       <= '0;
            q_sa_q       <= '0;
            max_action_q <= '0;
            r_address_q  <= '0;
            ready_q      <= 1'b1;
            w_en_q       <= 1'b0;
            done_q       <= 1'b0;
            w_address_q  <= '0;
            w_action_q   <= '0;
            w_data_q     <= '0;
        end else begin
            fsm_q        <= fsm_d;
            s_q          <= s_d;
            a_q          <= a_d;
            r_q          <= r_d;
            term_q       <= term_d;
            maxq_q       <= maxq_d;
            q_sa_q       <= q_sa_d;
            max_action_q <= max_action_d;
            r_address_q  <= r_address_d;
            ready_q      <= ready_d;
            w_en_q       <= w_en_d;
            done_q       <= done_d;
            w_address_q  <= w_address_d;
            w_action_q   <= w_action_d;
            w_data_q     <= w_data_d;
        end
    end

    assign ready      = ready_q;
    assign r_address  = r_address_q;
    assign w_en       = w_en_q;
    assign done       = done_q;
    assign w_address  = w_address_q;
    assign w_action   = w_action_q;
    assign w_data     = w_data_q;
    assign max_action = max_action_q;

endmodule

// File: tb/tb_q_update.sv
// Scoreboard bench for q_update: a behavioural Q table feeds r_data, a 64-bit reference model predicts each write.
// Build with Q_UPDATE_SATURATE_EN defined to exercise the clamping build.
module tb_q_update;

    typedef struct {
        logic [7:0]  addr;
        logic [1:0]  act;
        logic [31:0] data;
        logic [1:0]  maxa;
        int          cyc;
        logic        done;
    } rec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         ready;
    logic [7:0]   state_i;
    logic [1:0]   action_i;
    logic [7:0]   next_state_i;
    logic [31:0]  reward_i;
    logic         terminal_i;
    logic [7:0]   r_address;
    logic [127:0] r_data;
    logic         w_en;
    logic [7:0]   w_address;
    logic [1:0]   w_action;
    logic [31:0]  w_data;
    logic         done;
    logic [1:0]   max_action;

    logic [31:0]  tbl [256][4];
    logic [31:0]  ref_tbl [256][4];
    logic         load_en = 1'b0;
    logic [7:0]   load_s = '0;
    logic [31:0]  load_row [4];

    rec_t exp_q[$];
    rec_t obs_q[$];
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    q_update dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ready      (ready),
        .state      (state_i),
        .action     (action_i),
        .next_state (next_state_i),
        .reward     (reward_i),
        .terminal   (terminal_i),
        .r_address  (r_address),
        .r_data     (r_data),
        .w_en       (w_en),
        .w_address  (w_address),
        .w_action   (w_action),
        .w_data     (w_data),
        .done       (done),
        .max_action (max_action)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (w_en) tbl[w_address][w_action] <= w_data;
        else if (load_en) tbl[load_s] <= load_row;
    end

    assign r_data = {tbl[r_address][3], tbl[r_address][2], tbl[r_address][1], tbl[r_address][0]};

    always @(negedge clk) begin
        if (w_en) obs_q.push_back('{w_address, w_action, w_data, max_action, cyc, done});
    end

    function automatic logic [1:0] ref_argmax(input logic [31:0] row [4]);
        logic [1:0] idx = 2'd0;
        for (int k = 1; k < 4; k++)
            if ($signed(row[k]) > $signed(row[idx])) idx = 2'(k);
        return idx;
    endfunction

    function automatic logic [31:0] ref_new(input logic [31:0] q, input logic [31:0] r,
                                           input logic [31:0] mq, input bit term);
        longint qs = longint'($signed(q));
        longint rs = longint'($signed(r));
        longint g  = (longint'(32'h0000E666) * longint'($signed(mq))) >>> 16;
        longint t  = term ? rs : rs + g;
        longint n  = qs + ((t - qs) >>> 2);
`ifdef Q_UPDATE_SATURATE_EN
        if (n > 64'sd2147483647) n = 64'sd2147483647;
        if (n < -64'sd2147483648) n = -64'sd2147483648;
`endif
        return n[31:0];
    endfunction

    task automatic load(input logic [7:0] s, input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] w2, input logic [31:0] w3);
        load_s = s;
        load_row[0] = w0; load_row[1] = w1; load_row[2] = w2; load_row[3] = w3;
        ref_tbl[s] = load_row;
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    function automatic rec_t predict(input logic [7:0] s, input logic [1:0] a, input logic [7:0] sn,
                                     input logic [31:0] r, input bit term, input int at_cyc);
        rec_t e;
        logic [1:0] m = ref_argmax(ref_tbl[sn]);
        e.addr = s; e.act = a; e.maxa = m; e.cyc = at_cyc; e.done = 1'b1;
        e.data = ref_new(ref_tbl[s][a], r, ref_tbl[sn][m], term);
        return e;
    endfunction

    task automatic drive(input logic [7:0] s, input logic [1:0] a, input logic [7:0] sn,
                         input logic [31:0] r, input bit term);
        state_i = s; action_i = a; next_state_i = sn; reward_i = r; terminal_i = term;
    endtask

    task automatic send(input logic [7:0] s, input logic [1:0] a, input logic [7:0] sn,
                        input logic [31:0] r, input bit term);
        rec_t e;
        for (int k = 0; k < 20 && !ready; k++) @(negedge clk);
        drive(s, a, sn, r, term);
        start = 1'b1;
        e = predict(s, a, sn, r, term, cyc + 4);
        exp_q.push_back(e);
        ref_tbl[s][a] = e.data;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_obs(input int n, output bit ok);
        for (int k = 0; k < 40 && obs_q.size() < n; k++) @(negedge clk);
        ok = (obs_q.size() >= n);
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0;
        drive(8'd0, 2'd0, 8'd0, 32'd0, 1'b0);
        repeat (3) @(negedge clk);
        tests_run++; if (ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_ready: got %0b want 1", ready); end
        tests_run++; if (w_en !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_strobes: w_en=%0b done=%0b want 0 0", w_en, done); end
        tests_run++; if ({w_address, w_action, w_data, r_address, max_action} !== 52'd0) begin
            tests_failed++; $display("[TB] FAIL reset_outputs: wa=%h wact=%h wd=%h ra=%h ma=%h want all 0", w_address, w_action, w_data, r_address, max_action);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        rec_t e, o; bit ok;
        load(8'd3, 32'h0, 32'h0, 32'h0, 32'h0);
        load(8'd4, 32'h10000, 32'h20000, 32'h8000, 32'h0);
        send(8'd3, 2'd2, 8'd4, 32'h10000, 1'b0);
        wait_obs(1, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("[TB] FAIL basic_timeout: w_en count %0d want 1", obs_q.size()); end
        else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o.data !== 32'h0000B333) begin tests_failed++; $display("[TB] FAIL basic_data: got %h want 0000b333", o.data); end
            tests_run++; if (o.maxa !== 2'd1) begin tests_failed++; $display("[TB] FAIL basic_max_action: got %0d want 1", o.maxa); end
            tests_run++; if (o.addr !== 8'd3 || o.act !== 2'd2) begin tests_failed++; $display("[TB] FAIL basic_addr: got %0d/%0d want 3/2", o.addr, o.act); end
            tests_run++; if (o.cyc !== e.cyc) begin tests_failed++; $display("[TB] FAIL basic_latency: w_en cycle %0d want %0d", o.cyc, e.cyc); end
            tests_run++; if (o.done !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_done: got %0b want 1", o.done); end
        end
    endtask

    task automatic test_terminal();
        rec_t e, o; bit ok;
        load(8'd5, 32'h0, 32'h20000, 32'h0, 32'h0);
        load(8'd6, 32'h50000, 32'h0, 32'h70000, 32'h0);
        send(8'd5, 2'd1, 8'd6, 32'h0, 1'b1);
        wait_obs(1, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("[TB] FAIL terminal_timeout: w_en count %0d want 1", obs_q.size()); end
        else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o.data !== 32'h00018000) begin tests_failed++; $display("[TB] FAIL terminal_data: got %h want 00018000", o.data); end
            tests_run++; if (o.maxa !== e.maxa) begin tests_failed++; $display("[TB] FAIL terminal_max_action: got %0d want %0d", o.maxa, e.maxa); end
        end
    endtask

    task automatic test_saturate();
        rec_t e, o; bit ok; logic [31:0] want;
`ifdef Q_UPDATE_SATURATE_EN
        want = 32'h7FFFFFFF;
`else
        want = 32'h9CCB8666;
`endif
        load(8'd10, 32'h7FFF0000, 32'h0, 32'h0, 32'h0);
        load(8'd11, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000);
        send(8'd10, 2'd0, 8'd11, 32'h7FFF0000, 1'b0);
        wait_obs(1, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("[TB] FAIL saturate_timeout: w_en count %0d want 1", obs_q.size()); end
        else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o.data !== want) begin tests_failed++; $display("[TB] FAIL saturate_data: got %h want %h", o.data, want); end
            tests_run++; if (o.maxa !== 2'd0) begin tests_failed++; $display("[TB] FAIL saturate_max_action: got %0d want 0", o.maxa); end
        end
    endtask

    task automatic test_tie_negative();
        rec_t e, o; bit ok;
        load(8'd20, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFE0000, 32'hFFFF0000);
        load(8'd21, 32'h0, 32'h0, 32'h0, 32'h0);
        send(8'd21, 2'd3, 8'd20, 32'h0, 1'b0);
        wait_obs(1, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("[TB] FAIL tie_timeout: w_en count %0d want 1", obs_q.size()); end
        else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o.maxa !== 2'd0) begin tests_failed++; $display("[TB] FAIL tie_max_action: got %0d want 0", o.maxa); end
            tests_run++; if (o.data !== 32'hFFFFC666) begin tests_failed++; $display("[TB] FAIL tie_data: got %h want ffffc666", o.data); end
        end
    endtask

    task automatic test_ignore_start();
        rec_t e, o; bit ok;
        load(8'd50, 32'h30000, 32'h0, 32'h0, 32'h0);
        load(8'd51, 32'h0, 32'h0, 32'h0, 32'h10000);
        send(8'd50, 2'd0, 8'd51, 32'h8000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(8'd99, 2'd3, 8'd98, 32'h12345, 1'b1);
            start = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        repeat (10) @(negedge clk);
        tests_run++;
        if (obs_q.size() !== 1) begin tests_failed++; $display("[TB] FAIL ignore_start_count: w_en count %0d want 1", obs_q.size()); end
        if (obs_q.size() >= 1) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests_run++; if (o.data !== e.data || o.addr !== 8'd50) begin tests_failed++; $display("[TB] FAIL ignore_start_data: got %h@%0d want %h@50", o.data, o.addr, e.data); end
        end
        obs_q.delete();
    endtask

    task automatic test_back_to_back();
        rec_t e1, e2, o; bit ok; int acc;
        load(8'd30, 32'h10000, 32'h40000, 32'h0, 32'h0);
        for (int k = 0; k < 20 && !ready; k++) @(negedge clk);
        drive(8'd30, 2'd0, 8'd30, 32'h0, 1'b0);
        start = 1'b1;
        acc = cyc;
        e1 = predict(8'd30, 2'd0, 8'd30, 32'h0, 1'b0, acc + 4);
        ref_tbl[30][0] = e1.data;
        e2 = predict(8'd30, 2'd0, 8'd30, 32'h0, 1'b0, acc + 9);
        ref_tbl[30][0] = e2.data;
        repeat (6) @(negedge clk);
        start = 1'b0;
        wait_obs(2, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("[TB] FAIL b2b_timeout: w_en count %0d want 2", obs_q.size()); end
        else begin
            o = obs_q.pop_front();
            if (o.data !== 32'h0001A666) begin tests_failed++; $display("[TB] FAIL b2b_same_row_data: got %h want 0001a666", o.data); end
            tests_run++; if (o.cyc !== e1.cyc) begin tests_failed++; $display("[TB] FAIL b2b_first_cycle: got %0d want %0d", o.cyc, e1.cyc); end
            o = obs_q.pop_front();
            tests_run++; if (o.data !== e2.data) begin tests_failed++; $display("[TB] FAIL b2b_second_data: got %h want %h", o.data, e2.data); end
            tests_run++; if (o.cyc !== e2.cyc) begin tests_failed++; $display("[TB] FAIL b2b_second_cycle: got %0d want %0d", o.cyc, e2.cyc); end
        end
        repeat (6) @(negedge clk);
        tests_run++; if (obs_q.size() !== 0) begin tests_failed++; $display("[TB] FAIL b2b_extra_write: %0d extra w_en want 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_reset_mid();
        rec_t e, o; bit ok; logic [31:0] saved;
        load(8'd40, 32'h0, 32'h11000, 32'h0, 32'h0);
        load(8'd41, 32'h0, 32'h0, 32'h22000, 32'h0);
        saved = ref_tbl[40][1];
        send(8'd40, 2'd1, 8'd41, 32'h5000, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tests_run++; if (w_en !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_strobes: w_en=%0b done=%0b want 0 0", w_en, done); end
        tests_run++; if (ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL midreset_ready: got %0b want 1", ready); end
        tests_run++; if ({w_address, w_action, w_data, r_address, max_action} !== 52'd0) begin
            tests_failed++; $display("[TB] FAIL midreset_outputs: wa=%h wact=%h wd=%h ra=%h ma=%h want all 0", w_address, w_action, w_data, r_address, max_action);
        end
        reset = 1'b1;
        void'(exp_q.pop_back());
        ref_tbl[40][1] = saved;
        repeat (6) @(negedge clk);
        tests_run++; if (obs_q.size() !== 0) begin tests_failed++; $display("[TB] FAIL midreset_write: %0d w_en pulses want 0", obs_q.size()); end
        obs_q.delete();
        send(8'd40, 2'd1, 8'd41, 32'h5000, 1'b0);
        wait_obs(1, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("[TB] FAIL midreset_resume_timeout: w_en count %0d want 1", obs_q.size()); end
        else begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o.data !== e.data || o.maxa !== e.maxa) begin tests_failed++; $display("[TB] FAIL midreset_resume: got %h/%0d want %h/%0d", o.data, o.maxa, e.data, e.maxa); end
            tests_run++; if (o.cyc !== e.cyc) begin tests_failed++; $display("[TB] FAIL midreset_resume_latency: got %0d want %0d", o.cyc, e.cyc); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_terminal();
        test_saturate();
        test_tie_negative();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/q_update.md
# q_update

Temporal-difference update engine for the Dyna-Q datapath. It sits directly upstream of the Q-table storage. For each transition (s, a, r, s', terminal) it reads the 4-action Q row of s', then the row of s, and computes Q(s,a) + alpha*(r + gamma*max Q(s',·) - Q(s,a)). It then issues a single write back into the table. It also reports the greedy action of s', which the policy stage uses.

## Interface
Parameters:
- DATA_LENGTH, 32, signed fixed-point Q value width
- ACCESS_LENGTH, 8, state index width
- FRAC_BITS, 16, fractional bits of Q, reward and GAMMA
- GAMMA, 32'h0000E666, discount factor (unsigned, FRAC_BITS fraction, <1.0)
- ALPHA_SHIFT, 2, learning rate = 2^-ALPHA_SHIFT (arithmetic right shift)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  request pulse; accepted only when ready=1
- ready  out  1  high in IDLE
- state  in  ACCESS_LENGTH  current state s, sampled on accept
- action  in  2  action a taken in s, sampled on accept
- next_state  in  ACCESS_LENGTH  s', sampled on accept
- reward  in  DATA_LENGTH  signed r, sampled on accept
- terminal  in  1  s' terminal; sampled on accept
- r_address  out  ACCESS_LENGTH  table read index
- r_data  in  4*DATA_LENGTH  table row, combinational from r_address; action k at bits [k*DATA_LENGTH +: DATA_LENGTH]
- w_en  out  1  table write strobe, one cycle
- w_address  out  ACCESS_LENGTH  write state index
- w_action  out  2  write action index
- w_data  out  DATA_LENGTH  new Q(s,a)
- done  out  1  one-cycle pulse, coincident with w_en
- max_action  out  2  argmax over Q(s',·), held until next RD_NEXT

## Operation
- Reset values: ready=1, w_en=0, done=0, w_address=0, w_action=0, w_data=0, r_address=0, max_action=0. The FSM enters IDLE and all capture registers clear.
- FSM states: IDLE, RD_NEXT, RD_CUR, CALC, WRITE.
- IDLE: if start, latch all inputs and go to RD_NEXT. Otherwise stay.
- RD_NEXT: r_address=s'.
  - Register maxq as the signed maximum of the 4 words, and max_action as its index.
  - Ties resolve to the lowest index.
  - Then go to RD_CUR.
- RD_CUR: r_address=s. Register q_sa = word[a]. Then go to CALC.
- CALC, all arithmetic in DATA_LENGTH+2 signed bits:
  - g = (GAMMA * maxq) >>> FRAC_BITS, from a full 2*DATA_LENGTH product.
  - target = terminal ? r : r + g.
  - delta = target - q_sa.
  - new = q_sa + (delta >>> ALPHA_SHIFT).
  - Register new reduced to DATA_LENGTH (see Configuration). Then go to WRITE.
- WRITE: w_en=1, done=1, w_address=s, w_action=a, w_data=new. Then go to IDLE.
- start is ignored while ready=0; there is no queueing.
- When s == s', the second read sees pre-update data, which is correct because nothing is written before WRITE.

## Timing
- Accept at edge T, where start=1 and ready=1. States: RD_NEXT in cycle T+1, RD_CUR T+2, CALC T+3, WRITE T+4 (w_en=done=1). IDLE and ready=1 in T+5.
- Throughput is one update per 5 cycles. start held high continuously is accepted at T+5.
- The table write commits at the end of T+4, so the next transaction's reads (≥T+6) see the updated value.
- reset low at any edge: return to IDLE next cycle. An in-flight update is discarded, so w_en is never asserted for it.
- r_address is driven only in RD_NEXT and RD_CUR. In all other states it holds its last value.

## Configuration
- Q_UPDATE_SATURATE_EN defined: new is clamped to [-2^(DATA_LENGTH-1), 2^(DATA_LENGTH-1)-1], i.e. 0x80000000..0x7FFFFFFF at default width.
- Undefined: the low DATA_LENGTH bits are taken (two's-complement wrap).
- Intermediate widths are identical in both builds.

## Test plan
- Basic update: Q(3,·)=0, Q(4,·)={0x10000,0x20000,0x8000,0}, a=2, r=0x10000, terminal=0. Required: max_action=1, w_address=3, w_action=2, w_data=0xB333, w_en exactly at T+4.
- Terminal: Q(5,1)=0x20000, r=0, terminal=1, s'=6 arbitrary. Required: w_data=0x18000.
- Saturation: Q(s,a)=0x7FFF0000, r=0x7FFF0000, all Q(s')=0x7FFF0000, terminal=0. Required: w_data=0x7FFFFFFF with Q_UPDATE_SATURATE_EN; the wrapped low 32 bits without it.
- Tie and negative values: Q(s',·)={0xFFFF0000,0xFFFF0000,0xFFFE0000,0xFFFF0000}. Required: max_action=0 and maxq=-1.0.
- Handshake: start pulsed at T+1..T+4 is ignored (exactly one w_en). start held high gives w_en at T+4 and T+9. Transaction with s==s' uses the old row.
- Reset mid-op: reset=0 during CALC. Required: no w_en/done pulse, ready=1 the cycle after, outputs at reset values; the next start completes normally.
